operand_seq: RTL



---
 rtl/proc_pkg.sv | 53 +++++
 rtl/ea_adder.sv | 19 +
 rtl/operand_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared 6502 core definitions: addressing-mode codes, sequencer state indices,
// default vector addresses and status-register bit positions.
package proc_pkg;

    typedef enum logic [2:0] {
        M_IMP = 3'd0,
        M_IMM = 3'd1,
        M_ZP  = 3'd2,
        M_ZPI = 3'd3,
        M_ABS = 3'd4,
        M_ABI = 3'd5,
        M_IND = 3'd6,
        M_REL = 3'd7
    } mode_t;

    localparam int S_RESET   = 0;
    localparam int S_VEC_LO  = 1;
    localparam int S_VEC_HI  = 2;
    localparam int S_FETCH   = 3;
    localparam int S_DECODE  = 4;
    localparam int S_OPER_HI = 5;
    localparam int S_FIX     = 6;
    localparam int S_IND_LO  = 7;
    localparam int S_IND_HI  = 8;
    localparam int S_DONE    = 9;
    localparam int N_STATES  = 10;

    typedef enum logic [N_STATES-1:0] {
        ST_RESET   = 10'd1 << S_RESET,
        ST_VEC_LO  = 10'd1 << S_VEC_LO,
        ST_VEC_HI  = 10'd1 << S_VEC_HI,
        ST_FETCH   = 10'd1 << S_FETCH,
        ST_DECODE  = 10'd1 << S_DECODE,
        ST_OPER_HI = 10'd1 << S_OPER_HI,
        ST_FIX     = 10'd1 << S_FIX,
        ST_IND_LO  = 10'd1 << S_IND_LO,
        ST_IND_HI  = 10'd1 << S_IND_HI,
        ST_DONE    = 10'd1 << S_DONE
    } state_t;

    localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_NMI_VEC   = 16'hFFFA;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'hFFFE;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_V = 6;
    localparam int P_N = 7;

endpackage

// File: rtl/ea_adder.sv
// Effective-address adder: base + 8-bit index, with low-byte carry and a
// page-wrapped result (zero page when zp_mode, base page otherwise).
module ea_adder (
    input  logic [15:0] base,
    input  logic [7:0]  idx,
    input  logic        zp_mode,
    output logic [15:0] sum,
    output logic        carry,
    output logic [15:0] wrap
);

    logic [8:0] lo_sum;

    assign lo_sum = {1'b0, base[7:0]} + {1'b0, idx};
    assign carry  = lo_sum[8];
    assign sum    = base + {8'h00, idx};
    assign wrap   = zp_mode ? {8'h00, lo_sum[7:0]} : {base[15:8], lo_sum[7:0]};

endmodule

// File: rtl/operand_seq.sv
// 6502 fetch/operand sequencer: vector fetch, opcode fetch, operand reads and
// effective-address resolution, handing one instruction at a time to execute.
module operand_seq
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_VEC     = DEF_RESET_VEC,
    parameter logic [15:0] NMI_VEC       = DEF_NMI_VEC,
    parameter logic [15:0] IRQ_VEC       = DEF_IRQ_VEC,
    parameter bit          IND_PAGE_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] address,
    input  logic [7:0]  rd_data,
    input  logic [2:0]  mode,
    input  logic [7:0]  idx_x,
    input  logic [7:0]  idx_y,
    input  logic        irq_n,
    input  logic        irq_mask,
    input  logic        nmi_n,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand,
    output logic [15:0] eff_addr,
    output logic        page_cross,
    output logic [15:0] pc,
    output logic        op_valid,
    output logic        int_taken,
    output logic        int_nmi
);

    state_t      state, next_state;
    mode_t       mode_q, cur_mode;
    logic [7:0]  lo_q;
    logic [7:0]  target_lo;
    logic [15:0] fix_addr;
    logic        nmi_prev, nmi_pend;

    logic        nmi_fall, nmi_now, irq_now;
    logic        take_nmi, take_irq;
    logic [7:0]  idx_sel;
    logic [15:0] ea_base, ea_sum, ea_wrap;
    logic        ea_carry;
    logic [15:0] pc_inc;
    logic [15:0] ind_next;

    // The mode input is only trusted while the new opcode is being decoded;
    // later states use the latched copy.
    assign cur_mode = (state == ST_DECODE) ? mode_t'(mode) : mode_q;
    assign idx_sel  = opcode[0] ? idx_y : idx_x;
    assign ea_base  = (state == ST_DECODE) ? {8'h00, rd_data} : {rd_data, lo_q};
    assign pc_inc   = pc + 16'd1;
    assign ind_next = IND_PAGE_WRAP ? {address[15:8], address[7:0] + 8'd1}
                                    : address + 16'd1;

    assign nmi_fall = nmi_prev & ~nmi_n;
    assign nmi_now  = nmi_pend | nmi_fall;
    assign irq_now  = ~irq_n & ~irq_mask;
    assign take_nmi = (state == ST_DONE) & op_ready & nmi_now;
    assign take_irq = (state == ST_DONE) & op_ready & ~nmi_now & irq_now;

    ea_adder u_ea (
        .base    (ea_base),
        .idx     (idx_sel),
        .zp_mode (cur_mode == M_ZPI),
        .sum     (ea_sum),
        .carry   (ea_carry),
        .wrap    (ea_wrap)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_RESET:   next_state = ST_VEC_LO;
            ST_VEC_LO:  next_state = ST_VEC_HI;
            ST_VEC_HI:  next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_DECODE;
            ST_DECODE: begin
                case (cur_mode)
                    M_ABS, M_ABI, M_IND: next_state = ST_OPER_HI;
                    default:             next_state = ST_DONE;
                endcase
            end
            ST_OPER_HI: begin
                case (cur_mode)
                    M_ABI:   next_state = ea_carry ? ST_FIX : ST_DONE;
                    M_IND:   next_state = ST_IND_LO;
                    default: next_state = ST_DONE;
                endcase
            end
            ST_FIX:     next_state = ST_DONE;
            ST_IND_LO:  next_state = ST_IND_HI;
            ST_IND_HI:  next_state = ST_DONE;
            ST_DONE: begin
                if (op_ready) begin
                    next_state = (take_nmi || take_irq) ? ST_VEC_LO : ST_FETCH;
                end
            end
            default:    next_state = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            address    <= RESET_VEC;
            pc         <= 16'h0000;
            opcode     <= 8'hEA;
            operand    <= 8'h00;
            eff_addr   <= 16'h0000;
            page_cross <= 1'b0;
            op_valid   <= 1'b0;
            int_taken  <= 1'b0;
            int_nmi    <= 1'b0;
            nmi_pend   <= 1'b0;
            nmi_prev   <= 1'b1;
            mode_q     <= M_IMP;
            lo_q       <= 8'h00;
            target_lo  <= 8'h00;
            fix_addr   <= 16'h0000;
        end else begin
            int_taken <= 1'b0;
            op_valid  <= (next_state == ST_DONE);
            nmi_prev  <= nmi_n;
            // A fresh edge coinciding with NMI entry survives for the next handshake.
            nmi_pend  <= take_nmi ? (nmi_pend & nmi_fall) : (nmi_pend | nmi_fall);

            unique case (state)
                ST_RESET: address <= RESET_VEC;
                ST_VEC_LO: begin
                    lo_q    <= rd_data;
                    address <= address + 16'd1;
                end
                ST_VEC_HI: begin
                    pc      <= {rd_data, lo_q};
                    address <= {rd_data, lo_q};
                end
                ST_FETCH: begin
                    opcode     <= rd_data;
                    pc         <= pc_inc;
                    address    <= pc_inc;
                    page_cross <= 1'b0;
                end
                ST_DECODE: begin
                    mode_q <= cur_mode;
                    if (cur_mode != M_IMP) begin
                        pc      <= pc_inc;
                        address <= pc_inc;
                    end
                    case (cur_mode)
                        M_IMM, M_REL: begin
                            operand  <= rd_data;
                            eff_addr <= address;
                        end
                        M_ZP:                eff_addr <= {8'h00, rd_data};
                        M_ZPI:               eff_addr <= ea_wrap;
                        M_ABS, M_ABI, M_IND: lo_q <= rd_data;
                        default: ;
                    endcase
                end
                ST_OPER_HI: begin
                    pc <= pc_inc;
                    case (cur_mode)
                        M_ABI: begin
                            address <= pc_inc;
                            if (ea_carry) begin
                                page_cross <= 1'b1;
                                fix_addr   <= ea_sum;
                            end else begin
                                eff_addr <= ea_wrap;
                            end
                        end
                        M_IND: address <= {rd_data, lo_q};
                        default: begin
                            address  <= pc_inc;
                            eff_addr <= {rd_data, lo_q};
                        end
                    endcase
                end
                ST_FIX: eff_addr <= fix_addr;
                ST_IND_LO: begin
                    target_lo <= rd_data;
                    address   <= ind_next;
                end
                ST_IND_HI: begin
                    eff_addr <= {rd_data, target_lo};
                    address  <= pc;
                end
                ST_DONE: begin
                    if (op_ready) begin
                        if (take_nmi) begin
                            address   <= NMI_VEC;
                            int_taken <= 1'b1;
                            int_nmi   <= 1'b1;
                        end else if (take_irq) begin
                            address   <= IRQ_VEC;
                            int_taken <= 1'b1;
                            int_nmi   <= 1'b0;
                        end else begin
                            address <= pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
